video_adaptive_binarizer: RTL and testbench
===========================================

VIDEO_ADAPTIVE_BINARIZER -- requirements
Module: video_adaptive_binarizer

Interface
REQ-001 Parameter DEFAULT_THRESH, 8'd150: threshold used after reset and whenever no valid frame mean exists.
REQ-002 Parameter THRESH_OFFSET, 8'd0: unsigned value added to the frame mean.
REQ-003 Parameter MIN_PIXELS, 18'd1024: minimum valid pixels per frame for a threshold update.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 video_frame_valid  input  1  high for the duration of a frame.
REQ-007 video_line_valid  input  1  high for the duration of a line.
REQ-008 video_data_valid  input  1  qualifies video_data_in.
REQ-009 video_data_in  input  8  grey pixel.
REQ-010 video_frame_valid_out, video_line_valid_out, video_data_valid_out  output  1 each  framing delayed by one cycle.
REQ-011 video_data_out  output  8  binarized pixel, 8'hFF or 8'h00.
REQ-012 threshold_out  output  8  threshold applied to the current frame.
REQ-013 thresh_valid  output  1  high once threshold_out is derived from a measured frame mean.

Function
REQ-014 Datapath latency SHALL be exactly 1 cycle, with all framing outputs registered alongside video_data_out.
REQ-015 video_data_out SHALL be 8'hFF when video_data_in > active threshold, else 8'h00; it holds 8'h00 when video_data_valid is low.
REQ-016 The active threshold SHALL be latched on the rising edge of video_frame_valid and stay constant for the whole frame.
REQ-017 FSM states: IDLE, ACCUM, DIVIDE, UPDATE.
REQ-018 IDLE->ACCUM on a video_frame_valid rise; entering ACCUM clears the 26-bit sum and the 18-bit pixel count.
REQ-019 In ACCUM, each video_data_valid cycle SHALL add video_data_in to the sum and increment the count.
REQ-020 Both accumulators SHALL saturate at all-ones and never wrap.
REQ-021 ACCUM->DIVIDE on a video_frame_valid fall if count >= MIN_PIXELS; otherwise ACCUM->IDLE with the threshold unchanged.
REQ-022 DIVIDE SHALL start the divider and compute sum/count in exactly 26 cycles; DIVIDE->UPDATE when the divider signals done.
REQ-023 UPDATE (1 cycle): next threshold = min(quotient, 255) + THRESH_OFFSET, saturated at 255; set thresh_valid; ->IDLE.
REQ-024 A video_frame_valid rise during DIVIDE SHALL abort the divide, keep the old next threshold and go directly to ACCUM.
REQ-025 A video_frame_valid rise and fall in the same sampled cycle are impossible; a 1-cycle frame SHALL be treated as a frame with count 0.

Reset
REQ-026 On reset, all outputs SHALL be 0, threshold_out SHALL be DEFAULT_THRESH, thresh_valid SHALL be 0, the FSM SHALL be IDLE and the accumulators cleared.
REQ-027 Reset asserted mid-frame SHALL discard partial sums; after release, output begins at the next video_frame_valid rise.

Configuration
REQ-028 Macro ADAPTIVE_THRESH_EN defined: the full adaptive behaviour of REQ-017..REQ-025 applies.
REQ-029 Macro ADAPTIVE_THRESH_EN undefined: no FSM, accumulators or divider; threshold is fixed at DEFAULT_THRESH; thresh_valid is tied 0; datapath latency is unchanged.

Structure
REQ-030 Shared package vid_pkg SHALL hold SUM_W=26, CNT_W=18, DEFAULT_THRESH, and the FSM state encoding.
REQ-031 Sub-module serial_divider: restoring, 26-bit dividend, 18-bit divisor, start/done/abort, 1 bit per cycle.

Verification
REQ-032 Reset, then a 702x288 frame of constant 100 -> all outputs 00 (100 < 150); 28 cycles after frame end, threshold 100 and thresh_valid=1.
REQ-033 Next frame of constant 101 -> all outputs FF; threshold_out=100 throughout; after that frame, threshold 101.
REQ-034 Frame of 500 pixels at 200 -> no update (500 < MIN_PIXELS); threshold unchanged, thresh_valid unchanged.
REQ-035 Frame rise 10 cycles into DIVIDE -> divide aborted, next frame uses the previous threshold, new accumulation starts.
REQ-036 THRESH_OFFSET=200, mean 120 -> threshold saturates at 255; pixel 255 -> output 00.
REQ-037 Build without ADAPTIVE_THRESH_EN, ramp 0..255 -> FF exactly for inputs 151..255 with 1-cycle latency; thresh_valid stays 0.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared widths, reset threshold and FSM encoding for the adaptive video binarizer.
package vid_pkg;
    localparam int SUM_W = 26;
    localparam int CNT_W = 18;
    localparam logic [7:0] DEFAULT_THRESH = 8'd150;

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, UPDATE} state_t;
endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle: SUM_W-bit dividend by CNT_W-bit divisor.
// done pulses for one cycle once the last bit has been resolved; abort drops the operation.
module serial_divider import vid_pkg::*; (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);
    localparam int BC_W = $clog2(SUM_W);

    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] dvs_q;
    logic [BC_W-1:0]  bit_cnt;
    logic             busy;
    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   diff;

    // quotient doubles as the dividend shift register; remainder stays below divisor so the borrow is diff's MSB
    assign trial = {rem_q, quotient[SUM_W-1]};
    assign diff  = trial - {1'b0, dvs_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q    <= '0;
            dvs_q    <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                quotient <= dividend;
                dvs_q    <= divisor;
                rem_q    <= '0;
                bit_cnt  <= '0;
                busy     <= 1'b1;
            end else if (busy) begin
                if (!diff[CNT_W]) begin
                    rem_q    <= diff[CNT_W-1:0];
                    quotient <= {quotient[SUM_W-2:0], 1'b1};
                end else begin
                    rem_q    <= trial[CNT_W-1:0];
                    quotient <= {quotient[SUM_W-2:0], 1'b0};
                end
                bit_cnt <= bit_cnt + BC_W'(1);
                if (bit_cnt == BC_W'(SUM_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/video_adaptive_binarizer.sv
// Binarizes grey pixels against a per-frame threshold with one cycle of latency.
// ADAPTIVE_THRESH_EN: threshold tracks the previous frame's mean (+offset); otherwise fixed.
module video_adaptive_binarizer #(
    parameter logic [7:0]  DEFAULT_THRESH = vid_pkg::DEFAULT_THRESH,
    parameter logic [7:0]  THRESH_OFFSET  = 8'd0,
    parameter logic [17:0] MIN_PIXELS     = 18'd1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video_frame_valid,
    input  logic       video_line_valid,
    input  logic       video_data_valid,
    input  logic [7:0] video_data_in,
    output logic       video_frame_valid_out,
    output logic       video_line_valid_out,
    output logic       video_data_valid_out,
    output logic [7:0] video_data_out,
    output logic [7:0] threshold_out,
    output logic       thresh_valid
);
    import vid_pkg::*;

    logic       armed;
    logic [7:0] thr_eff;

    // armed rises once frame_valid is seen low, so a reset released mid-frame stays silent until the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed                 <= 1'b0;
            video_frame_valid_out <= 1'b0;
            video_line_valid_out  <= 1'b0;
            video_data_valid_out  <= 1'b0;
            video_data_out        <= 8'h00;
            threshold_out         <= DEFAULT_THRESH;
        end else begin
            armed                 <= armed | ~video_frame_valid;
            video_frame_valid_out <= video_frame_valid & armed;
            video_line_valid_out  <= video_line_valid & armed;
            video_data_valid_out  <= video_data_valid & armed;
            video_data_out        <= (video_data_valid && armed && (video_data_in > thr_eff)) ? 8'hFF : 8'h00;
            threshold_out         <= thr_eff;
        end
    end

`ifdef ADAPTIVE_THRESH_EN
    state_t           state, state_nx;
    logic             rise, fall;
    logic             div_start, div_abort, div_done;
    logic [SUM_W-1:0] sum_q, quotient;
    logic [CNT_W-1:0] cnt_q;
    logic [SUM_W:0]   sum_add;
    logic [7:0]       next_thr, next_thr_d, q_clamp;
    logic [8:0]       thr_sum;

    assign rise       = video_frame_valid & ~video_frame_valid_out & armed;
    assign fall       = ~video_frame_valid & video_frame_valid_out;
    assign sum_add    = {1'b0, sum_q} + (SUM_W+1)'(video_data_in);
    assign q_clamp    = (|quotient[SUM_W-1:8]) ? 8'hFF : quotient[7:0];
    assign thr_sum    = {1'b0, q_clamp} + {1'b0, THRESH_OFFSET};
    assign next_thr_d = (state == UPDATE) ? (thr_sum[8] ? 8'hFF : thr_sum[7:0]) : next_thr;
    // between frames the pending threshold is shown; inside a frame the value latched at its rise holds
    assign thr_eff    = (rise || !video_frame_valid) ? next_thr_d : threshold_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        div_start = 1'b0;
        div_abort = 1'b0;
        case (state)
            IDLE:   if (rise) state_nx = ACCUM;
            ACCUM:  if (fall) begin
                        if (cnt_q >= MIN_PIXELS) begin
                            state_nx  = DIVIDE;
                            div_start = 1'b1;
                        end else begin
                            state_nx  = IDLE;
                        end
                    end
            DIVIDE: if (rise) begin
                        state_nx  = ACCUM;
                        div_abort = 1'b1;
                    end else if (div_done) begin
                        state_nx  = UPDATE;
                    end
            UPDATE: state_nx = rise ? ACCUM : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q        <= '0;
            cnt_q        <= '0;
            next_thr     <= DEFAULT_THRESH;
            thresh_valid <= 1'b0;
        end else begin
            next_thr <= next_thr_d;
            if (state == UPDATE) thresh_valid <= 1'b1;
            if (rise) begin
                sum_q <= '0;
                cnt_q <= '0;
            end else if (state == ACCUM && video_frame_valid && video_data_valid) begin
                sum_q <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
                if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    serial_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (sum_q),
        .divisor  (cnt_q),
        .done     (div_done),
        .quotient (quotient)
    );
`else
    logic unused_cfg;

    assign unused_cfg   = ^{THRESH_OFFSET, MIN_PIXELS};
    assign thr_eff      = DEFAULT_THRESH;
    assign thresh_valid = 1'b0;
`endif
endmodule

// File: tb/tb_video_adaptive_binarizer.sv
// Scoreboard bench: two instances (offset 0 and 200) share stimulus; a model predicts outputs and thresholds.
module tb_video_adaptive_binarizer;
    localparam logic [7:0] DEF     = 8'd150;
    localparam int         MIN_PIX = 1024;
`ifdef ADAPTIVE_THRESH_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] frm;
        logic [7:0] d0, d1, t0, t1;
        logic       tchk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       fv, lv, dv;
    logic [7:0] din;
    logic       fv_o[2], lv_o[2], dv_o[2], tv_o[2];
    logic [7:0] dout[2], thr_o[2];

    exp_t       sb[$];
    int         n_chk = 0, n_pass = 0;
    logic [7:0] cur[2], nxt[2];
    int         off[2] = '{0, 200};
    bit         arm, fvd, tv_m;
    longint     sum;
    int         cnt;

    always #5 clk = ~clk;

    video_adaptive_binarizer u_dut0 (
        .clk(clk), .reset(reset), .video_frame_valid(fv), .video_line_valid(lv),
        .video_data_valid(dv), .video_data_in(din), .video_frame_valid_out(fv_o[0]),
        .video_line_valid_out(lv_o[0]), .video_data_valid_out(dv_o[0]),
        .video_data_out(dout[0]), .threshold_out(thr_o[0]), .thresh_valid(tv_o[0]));

    video_adaptive_binarizer #(.THRESH_OFFSET(8'd200)) u_dut1 (
        .clk(clk), .reset(reset), .video_frame_valid(fv), .video_line_valid(lv),
        .video_data_valid(dv), .video_data_in(din), .video_frame_valid_out(fv_o[1]),
        .video_line_valid_out(lv_o[1]), .video_data_valid_out(dv_o[1]),
        .video_data_out(dout[1]), .threshold_out(thr_o[1]), .thresh_valid(tv_o[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    // apply inputs now and record what the DUTs must show after the next posedge
    task automatic drive(input logic f, input logic l, input logic v, input logic [7:0] d);
        exp_t e;
        bit   rs;
        fv = f; lv = l; dv = v; din = d;
        rs = f && !fvd && arm;
        if (rs) begin
            sum = 0; cnt = 0;
        end else if (f && v && arm) begin
            sum += d; cnt++;
        end
        for (int k = 0; k < 2; k++)
            if (!f || rs) cur[k] = nxt[k];
        e.frm  = {f & arm, l & arm, v & arm};
        e.d0   = (v && arm && d > cur[0]) ? 8'hFF : 8'h00;
        e.d1   = (v && arm && d > cur[1]) ? 8'hFF : 8'h00;
        e.t0   = cur[0];
        e.t1   = cur[1];
        e.tchk = f;
        sb.push_back(e);
        fvd = f & arm;
        arm = arm | !f;
    endtask

    task automatic step(input logic f, input logic l, input logic v, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out0", {fv_o[0], lv_o[0], dv_o[0], dout[0]}, {e.frm, e.d0});
            chk("out1", {fv_o[1], lv_o[1], dv_o[1], dout[1]}, {e.frm, e.d1});
            if (e.tchk) begin
                chk("frame_thr0", thr_o[0], e.t0);
                chk("frame_thr1", thr_o[1], e.t1);
            end
        end
        drive(f, l, v, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_out", {fv_o[k], lv_o[k], dv_o[k], dout[k]}, 32'h0);
            chk("rst_thr", thr_o[k], DEF);
            chk("rst_tv", tv_o[k], 1'b0);
        end
        reset = 1'b0;
        arm = 0; fvd = 0; tv_m = 0; sum = 0; cnt = 0;
        for (int k = 0; k < 2; k++) begin
            cur[k] = DEF; nxt[k] = DEF;
        end
        drive(fv, lv, dv, din);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame(input int w, input int h, input int a, input int b, input int c);
        logic [7:0] px;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                px = 8'((x * a + y * b + c) & 255);
                step(1'b1, 1'b1, 1'b1, px);
            end
            step(1'b1, 1'b0, 1'b0, 8'h00);
            step(1'b1, 1'b0, 1'b0, 8'h00);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic upd_model();
        longint q, t;
        if (ADAPT && cnt >= MIN_PIX) begin
            q = sum / cnt;
            if (q > 255) q = 255;
            for (int k = 0; k < 2; k++) begin
                t = q + off[k];
                if (t > 255) t = 255;
                nxt[k] = 8'(t);
            end
            tv_m = 1;
        end
    endtask

    // let any divide finish, then compare the pending threshold and valid flag
    task automatic post(input int n);
        idle(n);
        upd_model();
        for (int k = 0; k < 2; k++) begin
            chk("post_thr", thr_o[k], nxt[k]);
            chk("post_tv", tv_o[k], tv_m);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; fv = 0; lv = 0; dv = 0; din = 0;
        do_reset();
        frame(256, 1, 1, 0, 0);         post(40);
        frame(32, 40, 0, 0, 100);       post(40);
        frame(32, 40, 0, 0, 101);       post(40);
        frame(25, 20, 0, 0, 200);       post(40);
        frame(32, 40, 7, 3, 0);         idle(10);
        frame(32, 40, 5, 11, 17);       post(40);
        step(1'b1, 1'b1, 1'b1, 8'd200); post(40);
        frame(256, 1, 1, 0, 0);         post(40);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (50) step(1'b1, 1'b1, 1'b1, 8'd220);
        do_reset();
        repeat (20) step(1'b1, 1'b1, 1'b1, 8'd255);
        idle(5);
        frame(256, 1, 1, 0, 0);         post(40);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
